// File: rtl/fsm_decrypt.sv
// rtl/fsm_decrypt.sv - RC4 keystream decryption FSM
// Purpose: walks the RC4 PRGA over a 256x8 S working RAM, XORs each keystream
// byte with the encrypted-message ROM and writes MSG_LEN plaintext bytes.
// Ports:
//   CLOCK_50, rst_n              clock, asynchronous active-low reset
//   Decrypt_Start / Finish_ack   run request (IDLE only) / consumer ack (DONE only)
//   Decrypt_Finish               high while in DONE
//   S_Address/S_Data/S_wren/S_q  S working RAM port (two-cycle read latency)
//   E_Address/E_q                encrypted-message ROM port (two-cycle read latency)
//   D_Address/D_Data/D_wren      decrypted-message RAM write port
module fsm_decrypt #(
    parameter int MSG_LEN = 32
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       Decrypt_Start,
    input  logic       Finish_ack,
    output logic       Decrypt_Finish,
    output logic [7:0] S_Address,
    output logic [7:0] S_Data,
    output logic       S_wren,
    input  logic [7:0] S_q,
    output logic [4:0] E_Address,
    input  logic [7:0] E_q,
    output logic [4:0] D_Address,
    output logic [7:0] D_Data,
    output logic       D_wren
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        INC_I    = 4'd1,
        RD_SI    = 4'd2,
        WAIT_SI  = 4'd3,
        LATCH_SI = 4'd4,
        RD_SJ    = 4'd5,
        WAIT_SJ  = 4'd6,
        LATCH_SJ = 4'd7,
        WR_SI    = 4'd8,
        WR_SJ    = 4'd9,
        RD_F     = 4'd10,
        WAIT_F   = 4'd11,
        WR_D     = 4'd12,
        DONE     = 4'd13
    } state_t;

    localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] f_q, f_d;
    logic [4:0] k_q, k_d;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            f_q     <= 8'd0;
            k_q     <= 5'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        j_d            = j_q;
        si_d           = si_q;
        sj_d           = sj_q;
        f_d            = f_q;
        k_d            = k_q;
        Decrypt_Finish = 1'b0;
        S_Address      = 8'd0;
        S_Data         = 8'd0;
        S_wren         = 1'b0;
        E_Address      = 5'd0;
        D_Address      = 5'd0;
        D_Data         = 8'd0;
        D_wren         = 1'b0;

        case (state_q)
            IDLE: begin
                if (Decrypt_Start) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = 5'd0;
                    state_d = INC_I;
                end
            end
            INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = RD_SI;
            end
            // Address is held through RD/WAIT/LATCH so the two-cycle RAM
            // delivers S[i] exactly in the LATCH cycle.
            RD_SI: begin
                S_Address = i_q;
                state_d   = WAIT_SI;
            end
            WAIT_SI: begin
                S_Address = i_q;
                state_d   = LATCH_SI;
            end
            LATCH_SI: begin
                S_Address = i_q;
                si_d      = S_q;
                j_d       = j_q + S_q;
                state_d   = RD_SJ;
            end
            RD_SJ: begin
                S_Address = j_q;
                state_d   = WAIT_SJ;
            end
            WAIT_SJ: begin
                S_Address = j_q;
                state_d   = LATCH_SJ;
            end
            // The keystream index is formed here so it is stable from RD_F on.
            LATCH_SJ: begin
                S_Address = j_q;
                sj_d      = S_q;
                f_d       = si_q + S_q;
                state_d   = WR_SI;
            end
            // When i == j both writes land on the same word with the same
            // value, so the swap degenerates to a no-op without special casing.
            WR_SI: begin
                S_Address = i_q;
                S_Data    = sj_q;
                S_wren    = 1'b1;
                state_d   = WR_SJ;
            end
            WR_SJ: begin
                S_Address = j_q;
                S_Data    = si_q;
                S_wren    = 1'b1;
                state_d   = RD_F;
            end
            RD_F: begin
                S_Address = f_q;
                E_Address = k_q;
                state_d   = WAIT_F;
            end
            WAIT_F: begin
                S_Address = f_q;
                E_Address = k_q;
                state_d   = WR_D;
            end
            WR_D: begin
                S_Address = f_q;
                E_Address = k_q;
                D_Address = k_q;
                D_Data    = S_q ^ E_q;
                D_wren    = 1'b1;
                if (k_q == LAST_K) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 5'd1;
                    state_d = INC_I;
                end
            end
            DONE: begin
                Decrypt_Finish = 1'b1;
                if (Finish_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fsm_decrypt.md
FSM_DECRYPT -- requirements
Module: fsm_decrypt

Interface
REQ-001 Parameter MSG_LEN, default 32, number of message bytes decrypted per run (k = 0..MSG_LEN-1).
REQ-002 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 Decrypt_Start  in  1  request to start one decryption run; sampled only in IDLE.
REQ-005 Finish_ack  in  1  acknowledge from the consumer; sampled only in DONE.
REQ-006 Decrypt_Finish  out  1  high only in DONE.
REQ-007 S_Address  out  8  S-memory (256x8 working RAM) address.
REQ-008 S_Data  out  8  S-memory write data.
REQ-009 S_wren  out  1  S-memory write enable.
REQ-010 S_q  in  8  S-memory read data.
REQ-011 E_Address  out  5  encrypted-message ROM address (k).
REQ-012 E_q  in  8  encrypted-message ROM read data.
REQ-013 D_Address  out  5  decrypted-message RAM address (k); this RAM is the one read by the checker.
REQ-014 D_Data  out  8  decrypted byte.
REQ-015 D_wren  out  1  decrypted-RAM write enable.

Function
REQ-016 Registers i, j, si, sj, f (8 bits) and k (5 bits) shall be internal; all i/j/index sums shall be modulo 256.
REQ-017 States: IDLE, INC_I, RD_SI, WAIT_SI, LATCH_SI, RD_SJ, WAIT_SJ, LATCH_SJ, WR_SI, WR_SJ, RD_F, WAIT_F, WR_D, DONE.
REQ-018 IDLE: when Decrypt_Start=1, clear i, j, k to 0 and go to INC_I; otherwise stay.
REQ-019 INC_I: i <= i+1 (255 wraps to 0).
REQ-020 RD_SI/WAIT_SI/LATCH_SI: S_Address=i; in LATCH_SI si <= S_q, j <= j+S_q.
REQ-021 RD_SJ/WAIT_SJ/LATCH_SJ: S_Address=j; in LATCH_SJ sj <= S_q.
REQ-022 Read latency: S_q/E_q are sampled on the edge ending the second cycle after the address is first driven; the address shall be held constant through the RD, WAIT and LATCH states.
REQ-023 WR_SI: S_Address=i, S_Data=sj, S_wren=1; WR_SJ: S_Address=j, S_Data=si, S_wren=1.
REQ-024 When i==j, both writes shall still occur, leaving S[i] unchanged.
REQ-025 RD_F/WAIT_F: S_Address=si+sj, E_Address=k.
REQ-026 WR_D: D_Address=k, D_Data=S_q XOR E_q, D_wren=1, with E_Address=k and S_Address=si+sj still held.
REQ-027 WR_D exit: if k==MSG_LEN-1 go to DONE, else k <= k+1 and go to INC_I.
REQ-028 Timing: 12 cycles per byte; byte k written in cycle 12+12k after the start-sampling edge; DONE is entered in cycle 12*MSG_LEN+1.
REQ-029 S_wren and D_wren shall be high only in WR_SI/WR_SJ and WR_D respectively, one cycle each.
REQ-030 DONE: Decrypt_Finish=1; go to IDLE on Finish_ack=1, else stay.
REQ-031 Decrypt_Start outside IDLE and Finish_ack outside DONE shall be ignored.
REQ-032 Decrypt_Start and Finish_ack both high in DONE: go to IDLE only; no run starts until Start is sampled in IDLE.
REQ-033 Unused state encodings shall return to IDLE on the next edge.
REQ-034 In states that do not drive them, outputs shall be 0.

Reset
REQ-035 rst_n=0 shall immediately force IDLE, i=j=k=si=sj=f=0, all addresses/data 0, S_wren=D_wren=Decrypt_Finish=0, including mid-run.
REQ-036 After rst_n rises, no memory access shall occur until Decrypt_Start is sampled in IDLE.

Verification
REQ-037 S identity (S[x]=x), E all 0x00, Start pulse -> D[0]=0x02, D[1]=0x05; after byte 1 S[2]=0x03, S[3]=0x02.
REQ-038 Same run -> D_wren pulses in cycles 12, 24, ..., 384 with D_Address 0..31; Decrypt_Finish rises in cycle 385.
REQ-039 S identity except S[1]=0xFF, S[0xFF]=0x01, E[0]=0xA5 -> j=0xFF, f index wraps to 0x00, D[0]=0xA5, S[1]=0x01, S[0xFF]=0xFF.
REQ-040 Finish_ack held low 10 cycles in DONE -> Decrypt_Finish stays 1; one ack pulse -> IDLE and Decrypt_Finish=0 on the next edge; Start pulses mid-run cause no restart (k continues).
REQ-041 rst_n low at cycle 50 -> all wren/Finish 0 immediately; after release, outputs stay 0 until Start; a new run begins with i=j=k=0.
REQ-042 Second Start after ack -> i=j=k restart at 0 and use the already-modified S contents, matching a software RC4 model that continues from that S.
